spmv_operand_feeder: RTL and testbench

SPMV_OPERAND_FEEDER -- requirements
Module: spmv_operand_feeder

---
 rtl/spmv_operand_feeder_if.sv | 60 ++++++
 rtl/spmv_operand_feeder.sv | 157 +++++++++++++++
 tb/tb_spmv_operand_feeder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_operand_feeder_if.sv
// Operand-feeder bus bundle.
//
// Groups every non-clock/reset signal of spmv_operand_feeder:
//   job control : i_start, i_row_ptr (17 CSR pointers, top entry = nnz),
//                 o_row_ptr, o_done
//   element mem : o_mem_en, o_elem_addr -> i_val_data, i_col_data (1-cycle latency)
//   vector mem  : o_vec_en, o_vec_addr  -> i_vec_data (1-cycle latency)
//   core side   : o_read_data_A, o_read_data_B, o_count, o_start, i_core_done
//   debug       : dbg_state (FSM state encoding)
//   optional    : o_err, present only when FEEDER_BOUNDS_CHECK_EN is defined
//
// Handshake semantics: there is no valid/ready pair on this bus. Memory
// reads are strobe-based (data is valid exactly one cycle after the strobe,
// no back-pressure); i_start is a level sampled only in IDLE; i_core_done is
// a level sampled only while the feeder waits in DRAIN.
//
// Modports: master = the feeder, slave = memories / core / job controller.
interface spmv_operand_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  i_start;
  logic [17*ADDR_W-1:0]  i_row_ptr;
  logic                  o_mem_en;
  logic [ADDR_W-1:0]     o_elem_addr;
  logic [DATA_W-1:0]     i_val_data;
  logic [ADDR_W-1:0]     i_col_data;
  logic                  o_vec_en;
  logic [3:0]            o_vec_addr;
  logic [DATA_W-1:0]     i_vec_data;
  logic [DATA_W-1:0]     o_read_data_A;
  logic [DATA_W-1:0]     o_read_data_B;
  logic [ADDR_W-1:0]     o_count;
  logic [17*ADDR_W-1:0]  o_row_ptr;
  logic                  o_start;
  logic                  i_core_done;
  logic                  o_done;
  logic [2:0]            dbg_state;
`ifdef FEEDER_BOUNDS_CHECK_EN
  logic                  o_err;
`endif

  modport master (
`ifdef FEEDER_BOUNDS_CHECK_EN
    output o_err,
`endif
    input  i_start, i_row_ptr, i_val_data, i_col_data, i_vec_data, i_core_done,
    output o_mem_en, o_elem_addr, o_vec_en, o_vec_addr, o_read_data_A,
    output o_read_data_B, o_count, o_row_ptr, o_start, o_done, dbg_state
  );

  modport slave (
`ifdef FEEDER_BOUNDS_CHECK_EN
    input  o_err,
`endif
    output i_start, i_row_ptr, i_val_data, i_col_data, i_vec_data, i_core_done,
    input  o_mem_en, o_elem_addr, o_vec_en, o_vec_addr, o_read_data_A,
    input  o_read_data_B, o_count, o_row_ptr, o_start, o_done, dbg_state
  );
endinterface

// File: rtl/spmv_operand_feeder.sv
// spmv_operand_feeder
//
// Walks the nonzero elements of one CSR job and presents (value, x[col])
// FP16 operand pairs to the SpMV core, one pair every 4 cycles:
//   FETCH  : read value/column memories at element e
//   INDEX  : value and column arrive; read dense vector at column
//   VECTOR : vector element arrives; pair, count=e+1 and o_start registered
//   WAIT   : loop back to FETCH while e < nnz, else DRAIN
// DRAIN waits (no timeout) for i_core_done, DONE pulses o_done once.
// A job with nnz = 0 goes straight to DONE.
//
// Ports:
//   i_clk  - sole clock, rising edge
//   i_rstn - asynchronous active-low reset, clears all state and outputs
//   bus    - spmv_operand_feeder_if.master (see the interface file)
//
// Optional feature: define FEEDER_BOUNDS_CHECK_EN to reject column indices
// >= 16 (B forced to 0, no vector read, sticky o_err cleared on job start).
// Without it, i_col_data[7:4] is ignored.
//
// Only DATA_W = 16 and ADDR_W = 8 are supported.
module spmv_operand_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  spmv_operand_feeder_if.master bus
);
  localparam int RP_W = 17 * ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_INDEX  = 3'd2,
    S_VECTOR = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] elem_idx;
  logic [DATA_W-1:0] val_q;
  logic [RP_W-1:0]   row_ptr_q;
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;
  logic [ADDR_W-1:0] count_q;
  logic              start_q;
  logic              done_q;
  logic [ADDR_W-1:0] nnz;
  logic              col_ok;

  // nnz comes from the captured pointers so a changing i_row_ptr mid-job
  // has no effect.
  assign nnz = row_ptr_q[RP_W-1 -: ADDR_W];

`ifdef FEEDER_BOUNDS_CHECK_EN
  logic bad_col_q;
  logic err_q;
  assign col_ok    = (bus.i_col_data[ADDR_W-1:4] == '0);
  assign bus.o_err = err_q;
`else
  logic unused_col_hi;
  assign col_ok        = 1'b1;
  assign unused_col_hi = ^bus.i_col_data[ADDR_W-1:4];
`endif

  // Memory strobes are decoded from the registered state: the vector
  // address depends on column data that only arrives during INDEX, so it
  // cannot be registered one cycle ahead. Gated to 0 outside their states.
  assign bus.o_mem_en    = (state == S_FETCH);
  assign bus.o_elem_addr = (state == S_FETCH) ? elem_idx : '0;
  assign bus.o_vec_en    = (state == S_INDEX) && col_ok;
  assign bus.o_vec_addr  = bus.o_vec_en ? bus.i_col_data[3:0] : 4'd0;

  assign bus.o_read_data_A = data_a_q;
  assign bus.o_read_data_B = data_b_q;
  assign bus.o_count       = count_q;
  assign bus.o_row_ptr     = row_ptr_q;
  assign bus.o_start       = start_q;
  assign bus.o_done        = done_q;
  assign bus.dbg_state     = state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      elem_idx  <= '0;
      val_q     <= '0;
      row_ptr_q <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      count_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef FEEDER_BOUNDS_CHECK_EN
      bad_col_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            row_ptr_q <= bus.i_row_ptr;
            elem_idx  <= '0;
`ifdef FEEDER_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
`endif
            if (bus.i_row_ptr[RP_W-1 -: ADDR_W] != '0) begin
              state <= S_FETCH;
            end else begin
              // Empty job: no core start, completion pulse next cycle.
              state   <= S_DONE;
              done_q  <= 1'b1;
              start_q <= 1'b0;
            end
          end
        end
        S_FETCH: state <= S_INDEX;
        S_INDEX: begin
          val_q <= bus.i_val_data;
`ifdef FEEDER_BOUNDS_CHECK_EN
          bad_col_q <= !col_ok;
          if (!col_ok) err_q <= 1'b1;
`endif
          state <= S_VECTOR;
        end
        S_VECTOR: begin
          data_a_q <= val_q;
`ifdef FEEDER_BOUNDS_CHECK_EN
          data_b_q <= bad_col_q ? '0 : bus.i_vec_data;
`else
          data_b_q <= bus.i_vec_data;
`endif
          count_q  <= elem_idx + 1'b1;
          elem_idx <= elem_idx + 1'b1;
          start_q  <= 1'b1;
          state    <= S_WAIT;
        end
        // elem_idx already holds the number of elements presented.
        S_WAIT: state <= (elem_idx < nnz) ? S_FETCH : S_DRAIN;
        S_DRAIN: begin
          if (bus.i_core_done) begin
            state   <= S_DONE;
            done_q  <= 1'b1;
            start_q <= 1'b0;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spmv_operand_feeder.sv
// Self-checking bench for spmv_operand_feeder.
// Memory and vector stores are modelled as arrays with 1-cycle read latency.
// For each job the reference model lists the operand pairs (A = value[e],
// B = vector[col[e]]) with the cycle each must appear (4 cycles per slot),
// the expected memory strobe addresses, and the cycle of the o_done pulse;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_spmv_operand_feeder;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RP_W   = 17 * ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spmv_operand_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spmv_operand_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  logic [DATA_W-1:0] val_mem [256];
  logic [ADDR_W-1:0] col_mem [256];
  logic [DATA_W-1:0] vec_mem [16];

  // Memories: data valid only the cycle after a strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      bus.i_val_data <= val_mem[bus.o_elem_addr];
      bus.i_col_data <= col_mem[bus.o_elem_addr];
    end else begin
      bus.i_val_data <= 16'($urandom);
      bus.i_col_data <= 8'($urandom);
    end
    if (bus.o_vec_en) bus.i_vec_data <= vec_mem[bus.o_vec_addr];
    else              bus.i_vec_data <= 16'($urandom);
  end

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  typedef struct {
    int              cyc;
    logic [RP_W-1:0] rp;
    logic            err;
  } done_t;

  pair_t             pair_q [$];
  done_t             done_q [$];
  logic [ADDR_W-1:0] mem_q  [$];
  logic [3:0]        vec_q  [$];

  task automatic check_eq(input string name, input logic [RP_W-1:0] act,
                          input logic [RP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic col_in_range(input logic [ADDR_W-1:0] col);
`ifdef FEEDER_BOUNDS_CHECK_EN
    return col < 16;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] model_b(input logic [ADDR_W-1:0] col);
    if (!col_in_range(col)) return '0;
    return vec_mem[col[3:0]];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*DATA_W+ADDR_W-1:0] prev;
    logic [2*DATA_W+ADDR_W-1:0] snap;
    pair_t p;
    done_t dn;
    prev = '0;
    forever begin
      @(negedge clk);
      snap = {bus.o_read_data_A, bus.o_read_data_B, bus.o_count};
      if (!rst_n) begin
        prev = '0;
      end else begin
        if (pair_q.size() > 0 && pair_q[0].cyc == cyc) begin
          p = pair_q.pop_front();
          check_eq("count", bus.o_count, p.count);
          check_eq("data_a", bus.o_read_data_A, p.a);
          check_eq("data_b", bus.o_read_data_B, p.b);
          check_eq("start_level", bus.o_start, 1'b1);
        end else if (snap !== prev) begin
          check_eq("hold_a_b_count", snap, prev);
        end
        prev = snap;

        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          dn = done_q.pop_front();
          check_eq("done_pulse", bus.o_done, 1'b1);
          check_eq("start_cleared", bus.o_start, 1'b0);
          check_eq("row_ptr_capture", bus.o_row_ptr, dn.rp);
`ifdef FEEDER_BOUNDS_CHECK_EN
          check_eq("err_sticky", bus.o_err, dn.err);
`endif
        end else if (bus.o_done !== 1'b0) begin
          check_eq("done_spurious", bus.o_done, 1'b0);
        end

        if (bus.o_mem_en) begin
          if (mem_q.size() == 0) check_eq("mem_en_spurious", bus.o_mem_en, 1'b0);
          else                   check_eq("elem_addr", bus.o_elem_addr, mem_q.pop_front());
        end
        if (bus.o_vec_en) begin
          if (vec_q.size() == 0) check_eq("vec_en_spurious", bus.o_vec_en, 1'b0);
          else                   check_eq("vec_addr", bus.o_vec_addr, vec_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_a"}, bus.o_read_data_A, '0);
    check_eq({tag, "_data_b"}, bus.o_read_data_B, '0);
    check_eq({tag, "_count"}, bus.o_count, '0);
    check_eq({tag, "_start"}, bus.o_start, '0);
    check_eq({tag, "_done"}, bus.o_done, '0);
    check_eq({tag, "_mem_en"}, bus.o_mem_en, '0);
    check_eq({tag, "_vec_en"}, bus.o_vec_en, '0);
    check_eq({tag, "_elem_addr"}, bus.o_elem_addr, '0);
    check_eq({tag, "_vec_addr"}, bus.o_vec_addr, '0);
    check_eq({tag, "_row_ptr"}, bus.o_row_ptr, '0);
`ifdef FEEDER_BOUNDS_CHECK_EN
    check_eq({tag, "_err"}, bus.o_err, '0);
`endif
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      val_mem[i] = 16'($urandom);
      col_mem[i] = 8'($urandom);
    end
    for (int i = 0; i < 16; i++) vec_mem[i] = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_start     = 1'b0;
      bus.i_core_done = 1'($urandom_range(0, 1));
      bus.i_row_ptr   = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    end
  endtask

  // Called at a negedge with the DUT in IDLE: the next edge samples i_start.
  // d = DRAIN cycles before i_core_done; rst_at != 0 resets while
  // count == rst_at. Returns at a negedge with the DUT back in IDLE.
  task automatic run_job(input int nnz, input int d, input bit keep_start,
                         input int rst_at);
    int              s;
    int              t;
    logic            any_bad;
    logic [127:0]    low;
    logic [RP_W-1:0] rp;
    pair_t           p;
    done_t           dn;
    low     = {$urandom, $urandom, $urandom, $urandom};
    rp      = {8'(nnz), low};
    any_bad = 1'b0;
    bus.i_row_ptr = rp;
    bus.i_start   = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= nnz; k++) begin
      if (!col_in_range(col_mem[k-1])) any_bad = 1'b1;
      if (rst_at == 0 || k <= rst_at) begin
        p.cyc   = s + 4 * k - 1;
        p.count = 8'(k);
        p.a     = val_mem[k-1];
        p.b     = model_b(col_mem[k-1]);
        pair_q.push_back(p);
        mem_q.push_back(8'(k - 1));
        if (col_in_range(col_mem[k-1])) vec_q.push_back(col_mem[k-1][3:0]);
      end
    end
    t = (nnz == 0) ? s : s + 4 * nnz + 1 + d;
    if (rst_at == 0) begin
      dn.cyc = t;
      dn.rp  = rp;
      dn.err = any_bad;
      done_q.push_back(dn);
    end
    for (int edge_n = s + 1; edge_n <= t + 1; edge_n++) begin
      @(negedge clk);
      if (rst_at != 0 && cyc == s + 4 * rst_at - 1) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_job_reset");
        bus.i_start     = 1'b0;
        bus.i_core_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bus.i_row_ptr   = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
      bus.i_start     = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
      if (edge_n <= s + 4 * nnz) bus.i_core_done = 1'($urandom_range(0, 1));
      else                       bus.i_core_done = (edge_n == t);
    end
    @(negedge clk);
    bus.i_start = keep_start;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_start     = 1'b0;
    bus.i_row_ptr   = '0;
    bus.i_core_done = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check_reset_outputs("power_on");
    rst_n = 1'b1;
    idle(2);

    // 10 elements of 16.0 against a vector of 2.0, core done 2 cycles late
    for (int i = 0; i < 256; i++) begin
      val_mem[i] = 16'h4C00;
      col_mem[i] = 8'($urandom_range(0, 15));
    end
    for (int i = 0; i < 16; i++) vec_mem[i] = 16'h4000;
    run_job(10, 2, 1'b0, 0);
    idle(2);

    // element 1: value 3.0, column 5, x[5] = 7.0; element 2 column 0x13
    fill_random();
    val_mem[1] = 16'h4200;
    col_mem[1] = 8'd5;
    vec_mem[5] = 16'h4700;
    col_mem[2] = 8'h13;
    run_job(4, 0, 1'b0, 0);
    idle(3);

    // empty job
    run_job(0, 0, 1'b0, 0);
    idle(2);

    // reset while count == 4, then a fresh job must start at count 1
    fill_random();
    run_job(8, 0, 1'b0, 4);
    idle(2);
    run_job(3, 1, 1'b0, 0);
    idle(2);

    // core done 6 cycles late, outputs frozen through DRAIN
    fill_random();
    run_job(10, 6, 1'b0, 0);
    idle(2);

    // i_start held high across back-to-back jobs, including an empty one
    fill_random();
    run_job(2, 1, 1'b1, 0);
    run_job(0, 0, 1'b1, 0);
    run_job(3, 0, 1'b0, 0);
    idle(2);

    for (int j = 0; j < 20; j++) begin
      bit keep;
      fill_random();
      keep = 1'($urandom_range(0, 1));
      run_job($urandom_range(0, 12), $urandom_range(0, 5), keep, 0);
      if (!keep) idle($urandom_range(1, 3));
    end
    idle(4);

    check_eq("pairs_outstanding", pair_q.size(), 0);
    check_eq("done_outstanding", done_q.size(), 0);
    check_eq("mem_reads_outstanding", mem_q.size(), 0);
    check_eq("vec_reads_outstanding", vec_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
